// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the multiplexed A/D RTC bus sequencers (write and read).
// State encoding, default phase timings and bus idle levels.
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StASetup,
    StAPulse,
    StAHold,
    StGap,
    StDSetup,
    StDPulse,
    StDHold,
    StDone
  } rtc_state_e;

  localparam int unsigned TSetupDef = 2;
  localparam int unsigned TPulseDef = 10;
  localparam int unsigned THoldDef  = 2;
  localparam int unsigned TGapDef   = 5;

  localparam logic CsIdle = 1'b1;
  localparam logic WrIdle = 1'b1;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // The timer holds T-1, so clog2(T) bits suffice; never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned t_max);
    return (t_max <= 1) ? 1 : $clog2(t_max);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that flags when it has reached zero.
module phase_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/rtc_write_seq.sv
// Write-cycle sequencer for the multiplexed A/D RTC bus: address phase, gap, data phase.
// Outputs are registered and decoded from the next state so they move with the state.
module rtc_write_seq
  import rtc_bus_pkg::*;
#(
  parameter int unsigned Largo  = 8,
  parameter int unsigned TSetup = TSetupDef,
  parameter int unsigned TPulse = TPulseDef,
  parameter int unsigned THold  = THoldDef,
  parameter int unsigned TGap   = TGapDef
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [Largo-1:0] addr_i,
  input  logic [Largo-1:0] data_i,
  output logic             wr_escritura_o,
  output logic             cs_n_o,
  output logic             ad_sel_o,
  output logic             rd_n_o,
  output logic [Largo-1:0] bus_out_o,
  output logic             bus_oe_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned TMax = max4(TSetup, TPulse, THold, TGap);
  localparam int unsigned TW   = timer_width(TMax);

  localparam logic [TW-1:0] LdSetup = TW'(TSetup - 1);
  localparam logic [TW-1:0] LdPulse = TW'(TPulse - 1);
  localparam logic [TW-1:0] LdHold  = TW'(THold - 1);
  localparam logic [TW-1:0] LdGap   = TW'(TGap - 1);

  rtc_state_e       state_q, state_d;
  logic [Largo-1:0] addr_q, addr_d;
  logic [Largo-1:0] data_q, data_d;
  logic             wr_q, cs_q, ad_sel_q, oe_q, busy_q, done_q;
  logic [Largo-1:0] bus_q;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;
  logic          a_phase_d, d_phase_d, pulse_d;

  phase_timer #(
    .Width(TW)
  ) u_timer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .zero_o    (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StASetup;
          addr_d   = addr_i;
          data_d   = data_i;
          tmr_load = 1'b1;
          tmr_val  = LdSetup;
        end
      end
      StASetup: if (tmr_zero) begin state_d = StAPulse; tmr_load = 1'b1; tmr_val = LdPulse; end
      StAPulse: if (tmr_zero) begin state_d = StAHold;  tmr_load = 1'b1; tmr_val = LdHold;  end
      StAHold:  if (tmr_zero) begin state_d = StGap;    tmr_load = 1'b1; tmr_val = LdGap;   end
      StGap:    if (tmr_zero) begin state_d = StDSetup; tmr_load = 1'b1; tmr_val = LdSetup; end
      StDSetup: if (tmr_zero) begin state_d = StDPulse; tmr_load = 1'b1; tmr_val = LdPulse; end
      StDPulse: if (tmr_zero) begin state_d = StDHold;  tmr_load = 1'b1; tmr_val = LdHold;  end
      StDHold:  if (tmr_zero) begin state_d = StDone;   tmr_load = 1'b1; end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    a_phase_d = state_d inside {StASetup, StAPulse, StAHold};
    d_phase_d = state_d inside {StDSetup, StDPulse, StDHold};
    pulse_d   = state_d inside {StAPulse, StDPulse};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= WrIdle;
      cs_q     <= CsIdle;
      ad_sel_q <= 1'b1;
      bus_q    <= '0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_q     <= pulse_d ? ~WrIdle : WrIdle;
      cs_q     <= (a_phase_d || d_phase_d) ? ~CsIdle : CsIdle;
      ad_sel_q <= ~a_phase_d;
      bus_q    <= a_phase_d ? addr_d : (d_phase_d ? data_d : '0);
      oe_q     <= a_phase_d || d_phase_d;
      busy_q   <= (state_d != StIdle);
      done_q   <= (state_d == StDone);
    end
  end

  assign wr_escritura_o = wr_q;
  assign cs_n_o         = cs_q;
  assign ad_sel_o       = ad_sel_q;
  assign rd_n_o         = 1'b1;
  assign bus_out_o      = bus_q;
  assign bus_oe_o       = oe_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_rtc_write_seq.sv
// Directed bench for rtc_write_seq: default timing instance plus an all-ones timing instance.
module tb_rtc_write_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       start_f = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data = 8'h00;

  logic       wr, cs, ads, rd, oe, busy, done;
  logic [7:0] bus;
  logic       wr_f, cs_f, ads_f, rd_f, oe_f, busy_f, done_f;
  logic [7:0] bus_f;

  int n_cmp = 0;
  int n_err = 0;

  // Per-sample capture, index 1 = state after the accepting edge.
  logic       wr_s[128], cs_s[128], ads_s[128], oe_s[128], busy_s[128], done_s[128];
  logic [7:0] bus_s[128];
  int done_first, done_cnt, busy_cnt, wl_a, wl_d;

  always #5 clk = ~clk;

  rtc_write_seq dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .addr_i(addr), .data_i(data),
    .wr_escritura_o(wr), .cs_n_o(cs), .ad_sel_o(ads), .rd_n_o(rd), .bus_out_o(bus),
    .bus_oe_o(oe), .busy_o(busy), .done_o(done)
  );

  rtc_write_seq #(.TSetup(1), .TPulse(1), .THold(1), .TGap(1)) dut_f (
    .clk_i(clk), .reset_i(reset), .start_i(start_f), .addr_i(addr), .data_i(data),
    .wr_escritura_o(wr_f), .cs_n_o(cs_f), .ad_sel_o(ads_f), .rd_n_o(rd_f), .bus_out_o(bus_f),
    .bus_oe_o(oe_f), .busy_o(busy_f), .done_o(done_f)
  );

  // Bus-protocol invariants on both instances, every cycle.
  always @(negedge clk) begin
    n_cmp++;
    if (rd !== 1'b1 || (wr === 1'b0 && cs !== 1'b0) || (cs === 1'b1 && oe !== 1'b0)) begin
      n_err++;
      $display("FAIL invariant_default t=%0t rd=%b wr=%b cs=%b oe=%b required rd=1, wr0->cs0, cs1->oe0",
               $time, rd, wr, cs, oe);
    end
    n_cmp++;
    if (rd_f !== 1'b1 || (wr_f === 1'b0 && cs_f !== 1'b0) || (cs_f === 1'b1 && oe_f !== 1'b0)) begin
      n_err++;
      $display("FAIL invariant_fast t=%0t rd=%b wr=%b cs=%b oe=%b required rd=1, wr0->cs0, cs1->oe0",
               $time, rd_f, wr_f, cs_f, oe_f);
    end
  end

  task automatic capture(input int n, input bit fast, input bit hold_start, input int chg_idx);
    done_first = -1; done_cnt = 0; busy_cnt = 0; wl_a = 0; wl_d = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      wr_s[i]   = fast ? wr_f   : wr;
      cs_s[i]   = fast ? cs_f   : cs;
      ads_s[i]  = fast ? ads_f  : ads;
      oe_s[i]   = fast ? oe_f   : oe;
      busy_s[i] = fast ? busy_f : busy;
      done_s[i] = fast ? done_f : done;
      bus_s[i]  = fast ? bus_f  : bus;
      if (done_s[i] === 1'b1) begin
        done_cnt++;
        if (done_first < 0) done_first = i;
      end
      if (busy_s[i] === 1'b1) busy_cnt++;
      if (wr_s[i] === 1'b0 && ads_s[i] === 1'b0) wl_a++;
      if (wr_s[i] === 1'b0 && ads_s[i] === 1'b1) wl_d++;
      if (i == 1 && !hold_start) begin start = 1'b0; start_f = 1'b0; end
      if (i == chg_idx) begin addr = 8'hFF; data = 8'hFF; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({wr, cs, ads, rd, bus, oe, busy, done} !== {4'b1111, 8'h00, 3'b000}) begin
      n_err++;
      $display("FAIL reset_default got wr/cs/ads/rd/bus/oe/busy/done=%b%b%b%b/%h/%b%b%b required 1111/00/000",
               wr, cs, ads, rd, bus, oe, busy, done);
    end
    n_cmp++;
    if ({wr_f, cs_f, ads_f, rd_f, bus_f, oe_f, busy_f, done_f} !== {4'b1111, 8'h00, 3'b000}) begin
      n_err++;
      $display("FAIL reset_fast got %b%b%b%b/%h/%b%b%b required 1111/00/000",
               wr_f, cs_f, ads_f, rd_f, bus_f, oe_f, busy_f, done_f);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    addr = 8'h21; data = 8'h45; start = 1'b1;
    capture(40, 1'b0, 1'b0, 0);
    n_cmp++;
    if (bus_s[1] !== 8'h21 || cs_s[1] !== 1'b0 || ads_s[1] !== 1'b0 || wr_s[1] !== 1'b1) begin
      n_err++;
      $display("FAIL single_a_setup bus=%h cs=%b ads=%b wr=%b required 21 0 0 1",
               bus_s[1], cs_s[1], ads_s[1], wr_s[1]);
    end
    n_cmp++;
    if (wl_a != 10) begin n_err++; $display("FAIL single_a_pulse_len got %0d required 10", wl_a); end
    n_cmp++;
    if (wl_d != 10) begin n_err++; $display("FAIL single_d_pulse_len got %0d required 10", wl_d); end
    n_cmp++;
    if (wr_s[3] !== 1'b0 || bus_s[3] !== 8'h21 || wr_s[12] !== 1'b0 || wr_s[13] !== 1'b1) begin
      n_err++;
      $display("FAIL single_a_pulse_window wr3=%b bus3=%h wr12=%b wr13=%b required 0 21 0 1",
               wr_s[3], bus_s[3], wr_s[12], wr_s[13]);
    end
    n_cmp++;
    if (cs_s[15] !== 1'b1 || oe_s[19] !== 1'b0 || cs_s[20] !== 1'b0) begin
      n_err++;
      $display("FAIL single_gap cs15=%b oe19=%b cs20=%b required 1 0 0", cs_s[15], oe_s[19], cs_s[20]);
    end
    n_cmp++;
    if (wr_s[22] !== 1'b0 || bus_s[22] !== 8'h45 || ads_s[22] !== 1'b1) begin
      n_err++;
      $display("FAIL single_d_pulse wr=%b bus=%h ads=%b required 0 45 1", wr_s[22], bus_s[22], ads_s[22]);
    end
    n_cmp++;
    if (done_first != 34 || done_cnt != 1) begin
      n_err++;
      $display("FAIL single_done idx=%0d cnt=%0d required 34 1", done_first, done_cnt);
    end
    n_cmp++;
    if (busy_cnt != 34) begin n_err++; $display("FAIL single_busy_len got %0d required 34", busy_cnt); end
  endtask

  task automatic test_back_to_back();
    int guard;
    addr = 8'h21; data = 8'h45; start = 1'b1;
    capture(80, 1'b0, 1'b1, 0);
    n_cmp++;
    if (done_first != 34 || done_s[69] !== 1'b1 || done_cnt != 2) begin
      n_err++;
      $display("FAIL b2b_done first=%0d d69=%b cnt=%0d required 34 1 2", done_first, done_s[69], done_cnt);
    end
    n_cmp++;
    if (done_s[35] !== 1'b0 || busy_s[35] !== 1'b0 || busy_s[36] !== 1'b1 || busy_s[70] !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_gap d35=%b b35=%b b36=%b b70=%b required 0 0 1 0",
               done_s[35], busy_s[35], busy_s[36], busy_s[70]);
    end
    start = 1'b0;
    guard = 0;
    while (busy !== 1'b0 && guard < 60) begin @(negedge clk); guard++; end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_drain busy=%b required 0", busy); end
    @(negedge clk);
  endtask

  task automatic test_latch();
    addr = 8'h21; data = 8'h45; start = 1'b1;
    capture(40, 1'b0, 1'b0, 13);
    n_cmp++;
    if (bus_s[14] !== 8'h21 || bus_s[20] !== 8'h45 || bus_s[22] !== 8'h45 || bus_s[32] !== 8'h45) begin
      n_err++;
      $display("FAIL latch_bus b14=%h b20=%h b22=%h b32=%h required 21 45 45 45",
               bus_s[14], bus_s[20], bus_s[22], bus_s[32]);
    end
    n_cmp++;
    if (done_first != 34) begin n_err++; $display("FAIL latch_done idx=%0d required 34", done_first); end
  endtask

  task automatic test_reset_mid();
    addr = 8'h21; data = 8'h45; start = 1'b1;
    capture(25, 1'b0, 1'b0, 0);
    n_cmp++;
    if (wr_s[25] !== 1'b0 || ads_s[25] !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_in_dpulse wr=%b ads=%b required 0 1", wr_s[25], ads_s[25]);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({wr, cs, oe, busy, done} !== 5'b11000) begin
      n_err++;
      $display("FAIL midrst_outputs wr/cs/oe/busy/done=%b%b%b%b%b required 11000", wr, cs, oe, busy, done);
    end
    reset = 1'b0;
    capture(5, 1'b0, 1'b0, 0);
    n_cmp++;
    if (done_cnt != 0 || busy_cnt != 0) begin
      n_err++;
      $display("FAIL midrst_no_done done=%0d busy=%0d required 0 0", done_cnt, busy_cnt);
    end
    addr = 8'h3C; data = 8'h5A; start = 1'b1;
    capture(40, 1'b0, 1'b0, 0);
    n_cmp++;
    if (done_first != 34 || bus_s[3] !== 8'h3C || bus_s[22] !== 8'h5A) begin
      n_err++;
      $display("FAIL midrst_restart done=%0d b3=%h b22=%h required 34 3c 5a", done_first, bus_s[3], bus_s[22]);
    end
  endtask

  task automatic test_min_timing();
    addr = 8'h7E; data = 8'h81; start_f = 1'b1;
    capture(12, 1'b1, 1'b0, 0);
    n_cmp++;
    if (done_first != 8 || done_cnt != 1 || busy_cnt != 8) begin
      n_err++;
      $display("FAIL min_done idx=%0d cnt=%0d busy=%0d required 8 1 8", done_first, done_cnt, busy_cnt);
    end
    n_cmp++;
    if (wl_a != 1 || wl_d != 1 || wr_s[2] !== 1'b0 || wr_s[6] !== 1'b0) begin
      n_err++;
      $display("FAIL min_pulses a=%0d d=%0d wr2=%b wr6=%b required 1 1 0 0", wl_a, wl_d, wr_s[2], wr_s[6]);
    end
    n_cmp++;
    if (bus_s[1] !== 8'h7E || cs_s[4] !== 1'b1 || oe_s[4] !== 1'b0 || bus_s[5] !== 8'h81 ||
        cs_s[7] !== 1'b0 || cs_s[8] !== 1'b1) begin
      n_err++;
      $display("FAIL min_phases b1=%h cs4=%b oe4=%b b5=%h cs7=%b cs8=%b required 7e 1 0 81 0 1",
               bus_s[1], cs_s[4], oe_s[4], bus_s[5], cs_s[7], cs_s[8]);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_latch();
    test_reset_mid();
    test_min_timing();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
